wombat_reg_arbiter: RTL

- Shares one register_block access port between two requesters: requester 0 is the UART command parser and requester 1 is an on-chip sequencer or host.
- Arbitrates round-robin and sequences single write or read transactions onto the register_block w/r strobes.
- Routes read data and completion back to the requester that was granted.
- Enforces an address-range check and a read-response timeout.

---
 rtl/wombat_regbus_pkg.sv | 30 +++
 rtl/wombat_reg_arbiter_rr_arb2.sv | 36 +++
 rtl/wombat_reg_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/wombat_regbus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wombat_regbus_pkg
//  Purpose  : Shared types and constants for the wombat register bus:
//             arbiter state encoding, default bus geometry and the command
//             bytes used by the UART command parser.
//  Revision : 1.0 - initial release
// ============================================================================
package wombat_regbus_pkg;

    // Default register bus geometry
    localparam int c_addr_width = 8;
    localparam int c_data_width = 32;
    localparam int c_reg_depth  = 16;

    // Command bytes shared with the UART command parser ('r' and 'w')
    localparam logic [7:0] READ_CMD  = 8'h72;
    localparam logic [7:0] WRITE_CMD = 8'h77;

    // Arbiter transaction sequencer states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WRITE     = 3'd1,
        ST_READ      = 3'd2,
        ST_READ_WAIT = 3'd3,
        ST_RESPOND   = 3'd4
    } arb_state_e;

endpackage : wombat_regbus_pkg
`default_nettype wire

// File: rtl/wombat_reg_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Purpose  : Two-request round-robin picker. Produces a one-hot grant from
//             the request vector and the current pointer, plus the pointer
//             value to adopt if that grant is taken. The pointer register
//             lives in the instantiating module.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    output logic [1:0] o_grant,
    output logic       o_ptr_next
);

    // Pick the lone requester, or the favoured one when both ask
    always_comb begin
        o_grant    = 2'b00;
        o_ptr_next = i_ptr;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = i_ptr ? 2'b10 : 2'b01;
            default: o_grant = 2'b00;
        endcase
        // After serving a requester, favour the other one next time
        if (o_grant[0]) begin
            o_ptr_next = 1'b1;
        end else if (o_grant[1]) begin
            o_ptr_next = 1'b0;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/wombat_reg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wombat_reg_arbiter
//  Purpose  : Shares one register_block access port between two requesters
//             (0 = UART command parser, 1 = sequencer/host). Round-robin
//             arbitration, single write/read sequencing, address range check
//             and read-response timeout. All outputs except o_req_ready are
//             registered.
//  Revision : 1.0 - initial release
// ============================================================================
module wombat_reg_arbiter
    import wombat_regbus_pkg::*;
#(
    parameter int ADDR_WIDTH = c_addr_width,
    parameter int DATA_WIDTH = c_data_width,
    parameter int REG_DEPTH  = c_reg_depth,
    parameter int TIMEOUT    = 15
) (
    input  logic                    clk,
    input  logic                    i_reset,
    input  logic [1:0]              i_req_valid,
    input  logic [1:0]              i_req_write,
    input  logic [2*ADDR_WIDTH-1:0] i_req_addr,
    input  logic [2*DATA_WIDTH-1:0] i_req_wdata,
    output logic [1:0]              o_req_ready,
    output logic [1:0]              o_rsp_valid,
    output logic                    o_rsp_err,
    output logic [DATA_WIDTH-1:0]   o_rsp_data,
    output logic                    o_w_en,
    output logic [ADDR_WIDTH-1:0]   o_w_addr,
    output logic [DATA_WIDTH-1:0]   o_w_value,
    output logic                    o_r_en,
    output logic [ADDR_WIDTH-1:0]   o_r_addr,
    input  logic [DATA_WIDTH-1:0]   i_r_value,
    input  logic                    i_r_valid
);

    // Timeout counter runs 0..TIMEOUT-1 while waiting for read data
    localparam int                    c_cnt_w     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0]    c_cnt_last  = c_cnt_w'(TIMEOUT - 1);
    localparam logic [ADDR_WIDTH:0]   c_reg_limit = (ADDR_WIDTH + 1)'(REG_DEPTH);

    arb_state_e              r_state_q,     w_state_d;
    logic                    r_ptr_q,       w_ptr_d;
    logic                    r_owner_q,     w_owner_d;
    logic [c_cnt_w-1:0]      r_cnt_q,       w_cnt_d;
    logic                    r_w_en_q,      w_w_en_d;
    logic [ADDR_WIDTH-1:0]   r_w_addr_q,    w_w_addr_d;
    logic [DATA_WIDTH-1:0]   r_w_value_q,   w_w_value_d;
    logic                    r_r_en_q,      w_r_en_d;
    logic [ADDR_WIDTH-1:0]   r_r_addr_q,    w_r_addr_d;
    logic [1:0]              r_rsp_valid_q, w_rsp_valid_d;
    logic                    r_rsp_err_q,   w_rsp_err_d;
    logic [DATA_WIDTH-1:0]   r_rsp_data_q,  w_rsp_data_d;

    logic [1:0]              w_grant;
    logic                    w_ptr_next;
    logic [1:0]              w_ready;
    logic                    w_accept;
    logic                    w_sel_write;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;
    logic [DATA_WIDTH-1:0]   w_sel_wdata;
    logic                    w_sel_illegal;

    rr_arb2 u_rr_arb2 (
        .i_req      (i_req_valid),
        .i_ptr      (r_ptr_q),
        .o_grant    (w_grant),
        .o_ptr_next (w_ptr_next)
    );

    // Ready only while idle; the picker guarantees at most one bit is set
    assign w_ready  = (r_state_q == ST_IDLE) ? w_grant : 2'b00;
    assign w_accept = |w_ready;

    // Mux the request fields of whichever requester is being accepted
    assign w_sel_write   = w_ready[1] ? i_req_write[1] : i_req_write[0];
    assign w_sel_addr    = w_ready[1] ? i_req_addr[ADDR_WIDTH +: ADDR_WIDTH]
                                      : i_req_addr[0 +: ADDR_WIDTH];
    assign w_sel_wdata   = w_ready[1] ? i_req_wdata[DATA_WIDTH +: DATA_WIDTH]
                                      : i_req_wdata[0 +: DATA_WIDTH];
    assign w_sel_illegal = ({1'b0, w_sel_addr} >= c_reg_limit);

    // Next-state and registered-output computation for the sequencer
    always_comb begin
        w_state_d     = r_state_q;
        w_ptr_d       = r_ptr_q;
        w_owner_d     = r_owner_q;
        w_cnt_d       = '0;
        w_w_en_d      = 1'b0;
        w_w_addr_d    = r_w_addr_q;
        w_w_value_d   = r_w_value_q;
        w_r_en_d      = 1'b0;
        w_r_addr_d    = r_r_addr_q;
        w_rsp_valid_d = 2'b00;
        w_rsp_err_d   = r_rsp_err_q;
        w_rsp_data_d  = r_rsp_data_q;

        case (r_state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    w_ptr_d   = w_ptr_next;
                    w_owner_d = w_ready[1];
                    if (w_sel_illegal) begin
                        // Out-of-range: answer immediately, touch nothing downstream
                        w_state_d    = ST_RESPOND;
                        w_rsp_err_d  = 1'b1;
                        w_rsp_data_d = '0;
                    end else if (w_sel_write) begin
                        w_state_d   = ST_WRITE;
                        w_w_en_d    = 1'b1;
                        w_w_addr_d  = w_sel_addr;
                        w_w_value_d = w_sel_wdata;
                    end else begin
                        w_state_d  = ST_READ;
                        w_r_en_d   = 1'b1;
                        w_r_addr_d = w_sel_addr;
                    end
                end
            end
            ST_WRITE: begin
                w_state_d    = ST_RESPOND;
                w_rsp_err_d  = 1'b0;
                w_rsp_data_d = '0;
            end
            ST_READ: begin
                w_state_d = ST_READ_WAIT;
            end
            ST_READ_WAIT: begin
                if (i_r_valid) begin
                    w_state_d    = ST_RESPOND;
                    w_rsp_err_d  = 1'b0;
                    w_rsp_data_d = i_r_value;
                end else if (r_cnt_q == c_cnt_last) begin
                    w_state_d    = ST_RESPOND;
                    w_rsp_err_d  = 1'b1;
                    w_rsp_data_d = '0;
                end else begin
                    w_cnt_d = r_cnt_q + c_cnt_w'(1);
                end
            end
            ST_RESPOND: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        // RESPOND always exits after one cycle, so entering it means one pulse
        if (w_state_d == ST_RESPOND) begin
            w_rsp_valid_d = w_owner_d ? 2'b10 : 2'b01;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_state_q     <= ST_IDLE;
            r_ptr_q       <= 1'b0;
            r_owner_q     <= 1'b0;
            r_cnt_q       <= '0;
            r_w_en_q      <= 1'b0;
            r_w_addr_q    <= '0;
            r_w_value_q   <= '0;
            r_r_en_q      <= 1'b0;
            r_r_addr_q    <= '0;
            r_rsp_valid_q <= 2'b00;
            r_rsp_err_q   <= 1'b0;
            r_rsp_data_q  <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_ptr_q       <= w_ptr_d;
            r_owner_q     <= w_owner_d;
            r_cnt_q       <= w_cnt_d;
            r_w_en_q      <= w_w_en_d;
            r_w_addr_q    <= w_w_addr_d;
            r_w_value_q   <= w_w_value_d;
            r_r_en_q      <= w_r_en_d;
            r_r_addr_q    <= w_r_addr_d;
            r_rsp_valid_q <= w_rsp_valid_d;
            r_rsp_err_q   <= w_rsp_err_d;
            r_rsp_data_q  <= w_rsp_data_d;
        end
    end

    assign o_req_ready = w_ready;
    assign o_rsp_valid = r_rsp_valid_q;
    assign o_rsp_err   = r_rsp_err_q;
    assign o_rsp_data  = r_rsp_data_q;
    assign o_w_en      = r_w_en_q;
    assign o_w_addr    = r_w_addr_q;
    assign o_w_value   = r_w_value_q;
    assign o_r_en      = r_r_en_q;
    assign o_r_addr    = r_r_addr_q;

endmodule : wombat_reg_arbiter
`default_nettype wire
